// File: rtl/tx_rx_defs.sv
// Shared constants and state encodings for the serial transmit/receive pair.
// TX and RX encodings sit side by side so both controllers agree on numbering.
package tx_rx_defs;

    localparam int DATA_W = 8;
    localparam int WORDS  = 4;
    localparam int ADR_W  = $clog2(WORDS);
    localparam int BIT_W  = $clog2(DATA_W);

    typedef enum logic [2:0] {
        TX_IDLE     = 3'd0,
        TX_LOAD     = 3'd1,
        TX_WAIT_RDY = 3'd2,
        TX_SEND     = 3'd3,
        TX_NEXT     = 3'd4,
        TX_FINISH   = 3'd5
    } tx_state_t;

    // Receiver walks sh1..sh8 in lockstep with the eight TX_SEND cycles.
    typedef enum logic [3:0] {
        RX_IDLE   = 4'd0,
        RX_SH1    = 4'd1,
        RX_SH2    = 4'd2,
        RX_SH3    = 4'd3,
        RX_SH4    = 4'd4,
        RX_SH5    = 4'd5,
        RX_SH6    = 4'd6,
        RX_SH7    = 4'd7,
        RX_SH8    = 4'd8,
        RX_WRITE  = 4'd9,
        RX_INC    = 4'd10,
        RX_FINISH = 4'd11
    } rx_state_t;

endpackage

// File: rtl/tx_shreg.sv
// Parallel-load, LSB-first right-shift register; load wins over shift.
// Zero fill keeps the line quiet if shifting ever runs past the word.
module tx_shreg
    import tx_rx_defs::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] d,
    output logic              q0
);

    logic [DATA_W-1:0] shreg_q, shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = d;
        end else if (shift) begin
            shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign q0 = shreg_q[0];

endmodule

// File: rtl/tx_serializer.sv
// Reads WORDS bytes from an async-read source, handshakes each with the receiver,
// then shifts it out LSB-first over DATA_W cycles. Finish is sticky until clr.
//
// state       | meaning
// ------------+-------------------------------------------------
// TX_IDLE     | waiting for start
// TX_LOAD     | capture rd_data at rd_adr = word_cnt
// TX_WAIT_RDY | Tx_vld high, waiting for Rx_ready
// TX_SEND     | one bit per cycle on Tx_data
// TX_NEXT     | advance word counter or finish
// TX_FINISH   | Tx_finish high, absorbing
module tx_serializer
    import tx_rx_defs::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    output logic [ADR_W-1:0]  rd_adr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              Rx_ready,
    output logic              Tx_vld,
    output logic              Tx_data,
    output logic              Tx_busy,
    output logic              Tx_finish
);

    tx_state_t        state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [ADR_W-1:0] word_cnt_q, word_cnt_d;
    logic             sh_load, sh_shift, sh_q0;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= TX_IDLE;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (start) begin
                    state_d    = TX_LOAD;
                    word_cnt_d = '0;
                end
            end
            TX_LOAD: begin
                sh_load = 1'b1;
                state_d = TX_WAIT_RDY;
            end
            TX_WAIT_RDY: begin
                if (Rx_ready) begin
                    state_d   = TX_SEND;
                    bit_cnt_d = '0;
                end
            end
            TX_SEND: begin
                sh_shift  = 1'b1;
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (bit_cnt_q == BIT_W'(DATA_W-1)) begin
                    state_d = TX_NEXT;
                end
            end
            TX_NEXT: begin
                // Stop before word_cnt can wrap; FINISH never leaves.
                if (word_cnt_q == ADR_W'(WORDS-1)) begin
                    state_d = TX_FINISH;
                end else begin
                    word_cnt_d = word_cnt_q + ADR_W'(1);
                    state_d    = TX_LOAD;
                end
            end
            TX_FINISH: state_d = TX_FINISH;
            default:   state_d = TX_IDLE;
        endcase
    end

    tx_shreg u_shreg (
        .clk   (clk),
        .clr   (clr),
        .load  (sh_load),
        .shift (sh_shift),
        .d     (rd_data),
        .q0    (sh_q0)
    );

    assign rd_adr    = word_cnt_q;
    assign Tx_vld    = (state_q == TX_WAIT_RDY);
    assign Tx_data   = (state_q == TX_SEND) && sh_q0;
    assign Tx_busy   = (state_q != TX_IDLE) && (state_q != TX_FINISH);
    assign Tx_finish = (state_q == TX_FINISH);

endmodule

// File: tb/tb_tx_serializer.sv
// Directed + randomized bench for tx_serializer: each transfer is checked cycle by
// cycle against the expected bit stream and per-word cycle cost.
module tb_tx_serializer;
    import tx_rx_defs::*;

    logic              clk = 1'b0;
    logic              clr;
    logic              start;
    logic [ADR_W-1:0]  rd_adr;
    logic [DATA_W-1:0] rd_data;
    logic              Rx_ready;
    logic              Tx_vld, Tx_data, Tx_busy, Tx_finish;

    logic [7:0] mem   [WORDS];
    int         waits [WORDS];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fin_rise_cyc = -1;
    logic fin_prev = 1'b0;

    always #5 clk = ~clk;

    assign rd_data = mem[rd_adr];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (Tx_finish && !fin_prev) fin_rise_cyc <= cyc;
        fin_prev <= Tx_finish;
    end

    tx_serializer dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .rd_adr    (rd_adr),
        .rd_data   (rd_data),
        .Rx_ready  (Rx_ready),
        .Tx_vld    (Tx_vld),
        .Tx_data   (Tx_data),
        .Tx_busy   (Tx_busy),
        .Tx_finish (Tx_finish)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic vld, input logic dat,
                            input logic busy, input logic fin);
        chk({tag, "_vld"},  32'(Tx_vld),    32'(vld));
        chk({tag, "_data"}, 32'(Tx_data),   32'(dat));
        chk({tag, "_busy"}, 32'(Tx_busy),   32'(busy));
        chk({tag, "_fin"},  32'(Tx_finish), 32'(fin));
    endtask

    // Holds clr low with random inputs, then releases and confirms idle.
    task automatic reset_phase();
        clr = 1'b0;
        repeat (3) begin
            start    = 1'($urandom);
            Rx_ready = 1'($urandom);
            foreach (mem[i]) mem[i] = 8'($urandom);
            @(posedge clk); #1;
            chk_outs("rst", 1'b0, 1'b0, 1'b0, 1'b0);
            chk("rst_adr", 32'(rd_adr), 32'd0);
        end
        clr   = 1'b1;
        start = 1'b0;
        repeat (2) begin
            Rx_ready = 1'($urandom);
            @(posedge clk); #1;
            chk_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0);
            chk("idle_adr", 32'(rd_adr), 32'd0);
        end
    endtask

    // One full transfer of mem[] with waits[w] extra not-ready cycles per word.
    // abort_w/abort_b select a SEND bit at which clr is dropped mid-cycle.
    task automatic run_transfer(input int abort_w, input int abort_b);
        int sumw;
        int start_cyc;
        sumw = 0;
        foreach (waits[i]) sumw += waits[i];
        start = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        for (int w = 0; w < WORDS; w++) begin
            chk_outs("load", 1'b0, 1'b0, 1'b1, 1'b0);
            chk("load_adr", 32'(rd_adr), 32'(w));
            Rx_ready = 1'($urandom);
            start    = 1'($urandom);
            @(posedge clk); #1;
            for (int i = 0; i < waits[w]; i++) begin
                Rx_ready = 1'b0;
                start    = 1'($urandom);
                chk_outs("wait", 1'b1, 1'b0, 1'b1, 1'b0);
                @(posedge clk); #1;
            end
            Rx_ready = 1'b1;
            chk_outs("wait_hs", 1'b1, 1'b0, 1'b1, 1'b0);
            chk("wait_adr", 32'(rd_adr), 32'(w));
            @(posedge clk); #1;
            for (int k = 0; k < DATA_W; k++) begin
                Rx_ready = 1'($urandom);
                start    = 1'($urandom);
                chk_outs($sformatf("send_w%0d_b%0d", w, k), 1'b0, mem[w][k], 1'b1, 1'b0);
                if (w == abort_w && k == abort_b) begin
                    clr = 1'b0;
                    #1;
                    chk_outs("abort", 1'b0, 1'b0, 1'b0, 1'b0);
                    chk("abort_adr", 32'(rd_adr), 32'd0);
                    return;
                end
                @(posedge clk); #1;
            end
            Rx_ready = 1'($urandom);
            chk_outs("next", 1'b0, 1'b0, 1'b1, 1'b0);
            chk("next_adr", 32'(rd_adr), 32'(w));
            @(posedge clk); #1;
        end
        chk_outs("finish", 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) begin
            start    = 1'($urandom);
            Rx_ready = 1'($urandom);
            @(posedge clk); #1;
            chk_outs("fin_hold", 1'b0, 1'b0, 1'b0, 1'b1);
            chk("fin_adr", 32'(rd_adr), 32'(WORDS-1));
        end
        // Each word costs LOAD + (waits+1) + DATA_W + NEXT cycles.
        chk("fin_latency", 32'(fin_rise_cyc - start_cyc),
            32'(WORDS * (DATA_W + 3) + sumw));
        start = 1'b0;
    endtask

    initial begin
        clr      = 1'b0;
        start    = 1'b0;
        Rx_ready = 1'b0;
        foreach (mem[i]) mem[i] = 8'h00;
        foreach (waits[i]) waits[i] = 0;

        reset_phase();
        mem = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
        waits = '{0, 0, 0, 0};
        run_transfer(-1, -1);

        reset_phase();
        mem = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
        waits = '{0, 5, 0, 0};
        run_transfer(-1, -1);

        repeat (3) begin
            reset_phase();
            foreach (mem[i]) mem[i] = 8'($urandom);
            foreach (waits[i]) waits[i] = int'($urandom_range(0, 3));
            run_transfer(-1, -1);
        end

        reset_phase();
        mem = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
        waits = '{0, 0, 0, 0};
        run_transfer(2, 4);
        reset_phase();
        mem = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
        run_transfer(-1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
